// File: rtl/eld_tracker_if.sv
// eld_tracker_if: issue, response, writeback and scoreboard signals of the external-load tracker.
interface eld_tracker_if #(
    parameter int unsigned N_ENTRY = 4
);
    localparam int unsigned TAG_W  = $clog2(N_ENTRY);
    localparam int unsigned RD_W   = 5;
    localparam int unsigned DATA_W = 32;

    logic              iss_val;
    logic [RD_W-1:0]   iss_rd;
    logic              iss_rdy;
    logic [TAG_W-1:0]  iss_tag;

    logic              rsp_val;
    logic [TAG_W-1:0]  rsp_tag;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    logic              wb_val;
    logic [RD_W-1:0]   wb_rd;
    logic [DATA_W-1:0] wb_data;

    logic              clr_op_ready_val;
    logic [RD_W-1:0]   clr_op_ready_idx;
    logic              set_op_ready_val;
    logic [RD_W-1:0]   set_op_ready_idx;

    logic              busy;

    modport master (
        output iss_val, iss_rd, rsp_val, rsp_tag, rsp_data,
        input  iss_rdy, iss_tag, rsp_err, wb_val, wb_rd, wb_data,
        input  clr_op_ready_val, clr_op_ready_idx, set_op_ready_val, set_op_ready_idx, busy
    );

    modport slave (
        input  iss_val, iss_rd, rsp_val, rsp_tag, rsp_data,
        output iss_rdy, iss_tag, rsp_err, wb_val, wb_rd, wb_data,
        output clr_op_ready_val, clr_op_ready_idx, set_op_ready_val, set_op_ready_idx, busy
    );
endinterface

// File: rtl/eld_tracker.sv
// eld_tracker: allocates tags for outstanding external loads and drives GPR scoreboard clear/set.
// Optional ELD_TRK_MULTI_RD_EN: several pending loads may target one rd (youngest-writer tracking).
module eld_tracker #(
    parameter int unsigned N_ENTRY = 4
) (
    input  logic         clk,
    input  logic         arst_n,
    eld_tracker_if.slave bus
);
    localparam int unsigned TAG_W = $clog2(N_ENTRY);
    localparam int unsigned RD_W  = 5;

    logic [N_ENTRY-1:0] valid_q, valid_d;
    logic [RD_W-1:0]    rd_q [N_ENTRY];
    logic [RD_W-1:0]    rd_d [N_ENTRY];
`ifdef ELD_TRK_MULTI_RD_EN
    logic [N_ENTRY-1:0] young_q, young_d;
`endif

    logic               any_free;
    logic               rd_conflict;
    logic [TAG_W-1:0]   alloc_tag;
    logic               iss_ok;
    logic               iss_fire;
    logic               clr_val;
    logic               rsp_hit;
    logic               rsp_young;
    logic [RD_W-1:0]    rsp_rd;
    logic               rsp_wb;

    // Lowest free entry wins; without multi-rd, a pending writer to iss_rd blocks issue.
    always_comb begin
        any_free    = 1'b0;
        alloc_tag   = '0;
        rd_conflict = 1'b0;
        for (int unsigned i = 0; i < N_ENTRY; i++) begin
            if (!valid_q[i] && !any_free) begin
                any_free  = 1'b1;
                alloc_tag = TAG_W'(i);
            end
`ifndef ELD_TRK_MULTI_RD_EN
            if (valid_q[i] && (rd_q[i] == bus.iss_rd) && (bus.iss_rd != '0)) begin
                rd_conflict = 1'b1;
            end
`endif
        end
    end

    assign iss_ok   = any_free && !rd_conflict;
    assign iss_fire = bus.iss_val && iss_ok;
    assign clr_val  = iss_fire && (bus.iss_rd != '0);

    assign bus.iss_rdy          = iss_ok;
    assign bus.iss_tag          = alloc_tag;
    assign bus.clr_op_ready_val = clr_val;
    assign bus.clr_op_ready_idx = clr_val ? bus.iss_rd : '0;

    assign rsp_hit = bus.rsp_val && valid_q[bus.rsp_tag];
    assign rsp_rd  = rd_q[bus.rsp_tag];
    assign rsp_wb  = rsp_hit && (rsp_rd != '0);

    // A same-cycle issue to the same rd strips youngest from the responding entry.
`ifdef ELD_TRK_MULTI_RD_EN
    assign rsp_young = young_q[bus.rsp_tag] && !(iss_fire && (bus.iss_rd == rsp_rd));
`else
    assign rsp_young = 1'b1;
`endif

    // Entry table next state: free on response, then allocate on issue.
    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
`ifdef ELD_TRK_MULTI_RD_EN
        young_d = young_q;
`endif
        if (rsp_hit) begin
            valid_d[bus.rsp_tag] = 1'b0;
        end
        if (iss_fire) begin
`ifdef ELD_TRK_MULTI_RD_EN
            for (int unsigned i = 0; i < N_ENTRY; i++) begin
                if (valid_q[i] && (rd_q[i] == bus.iss_rd)) begin
                    young_d[i] = 1'b0;
                end
            end
            young_d[alloc_tag] = 1'b1;
`endif
            valid_d[alloc_tag] = 1'b1;
            rd_d[alloc_tag]    = bus.iss_rd;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < N_ENTRY; i++) begin
                rd_q[i] <= '0;
            end
`ifdef ELD_TRK_MULTI_RD_EN
            young_q <= '0;
`endif
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
`ifdef ELD_TRK_MULTI_RD_EN
            young_q <= young_d;
`endif
        end
    end

    // Registered writeback, scoreboard set, error pulse and busy.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            bus.wb_val           <= 1'b0;
            bus.wb_rd            <= '0;
            bus.wb_data          <= '0;
            bus.set_op_ready_val <= 1'b0;
            bus.set_op_ready_idx <= '0;
            bus.rsp_err          <= 1'b0;
            bus.busy             <= 1'b0;
        end else begin
            bus.wb_val           <= rsp_wb;
            bus.set_op_ready_val <= rsp_wb && rsp_young;
            bus.rsp_err          <= bus.rsp_val && !valid_q[bus.rsp_tag];
            bus.busy             <= |valid_d;
            if (rsp_wb) begin
                bus.wb_rd            <= rsp_rd;
                bus.wb_data          <= bus.rsp_data;
                bus.set_op_ready_idx <= rsp_rd;
            end
        end
    end
endmodule

// File: tb/tb_eld_tracker.sv
// tb_eld_tracker: directed and randomized checks of eld_tracker against a sequence-number reference model.
module tb_eld_tracker;
    localparam int unsigned N_ENTRY = 4;

    logic clk    = 1'b0;
    logic arst_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    eld_tracker_if #(.N_ENTRY(N_ENTRY)) bus ();
    eld_tracker #(.N_ENTRY(N_ENTRY)) dut (.clk(clk), .arst_n(arst_n), .bus(bus));

    always #5 clk = ~clk;

    // Reference model: a load sets ready only if no later load to its rd was issued by its response edge.
    bit         m_valid [N_ENTRY];
    logic [4:0] m_rd    [N_ENTRY];
    int         m_seq   [N_ENTRY];
    int         last_seq [32];
    int         seq_ctr = 0;

    logic       exp_rdy, obs_rdy, exp_clr_val, obs_clr_val;
    logic [1:0] exp_tag, obs_tag;
    logic [4:0] exp_clr_idx, obs_clr_idx;
    logic       exp_wb_val, exp_set_val, exp_err, exp_busy;
    logic [4:0] exp_wb_rd, exp_set_idx;
    logic [31:0] exp_wb_data;

    task automatic drive_cycle(input logic iv, input logic [4:0] ird, input logic rv,
                               input logic [1:0] rtag, input logic [31:0] rdata);
        logic any_free, conflict, fire, hit;
        logic [4:0] r;
        bus.iss_val = iv; bus.iss_rd = ird; bus.rsp_val = rv; bus.rsp_tag = rtag; bus.rsp_data = rdata;
        any_free = 1'b0; conflict = 1'b0; exp_tag = 2'd0;
        for (int i = N_ENTRY - 1; i >= 0; i--) if (!m_valid[i]) begin any_free = 1'b1; exp_tag = 2'(i); end
`ifndef ELD_TRK_MULTI_RD_EN
        for (int i = 0; i < N_ENTRY; i++) if (m_valid[i] && m_rd[i] == ird && ird != 5'd0) conflict = 1'b1;
`endif
        exp_rdy     = any_free && !conflict;
        fire        = iv && exp_rdy;
        exp_clr_val = fire && (ird != 5'd0);
        exp_clr_idx = exp_clr_val ? ird : 5'd0;
        @(negedge clk);
        obs_rdy = bus.iss_rdy; obs_tag = bus.iss_tag;
        obs_clr_val = bus.clr_op_ready_val; obs_clr_idx = bus.clr_op_ready_idx;
        hit     = rv && m_valid[rtag];
        exp_err = rv && !m_valid[rtag];
        if (fire) begin seq_ctr++; last_seq[ird] = seq_ctr; end
        exp_wb_val = 1'b0; exp_set_val = 1'b0;
        if (hit) begin
            r           = m_rd[rtag];
            exp_wb_val  = (r != 5'd0);
            exp_wb_rd   = r;
            exp_wb_data = rdata;
            exp_set_val = (r != 5'd0) && (last_seq[r] == m_seq[rtag]);
            exp_set_idx = r;
            m_valid[rtag] = 1'b0;
        end
        if (fire) begin m_valid[exp_tag] = 1'b1; m_rd[exp_tag] = ird; m_seq[exp_tag] = seq_ctr; end
        exp_busy = 1'b0;
        for (int i = 0; i < N_ENTRY; i++) if (m_valid[i]) exp_busy = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        arst_n = 1'b0;
        bus.iss_val = 1'b0; bus.iss_rd = 5'd0; bus.rsp_val = 1'b0; bus.rsp_tag = 2'd0; bus.rsp_data = 32'd0;
        for (int i = 0; i < N_ENTRY; i++) m_valid[i] = 1'b0;
        #2;
    endtask

    task automatic release_reset();
        @(negedge clk); arst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1; apply_reset();
        checks++; if (bus.iss_rdy !== 1'b1) begin failures++; $display("FAIL reset_iss_rdy got=%0d exp=1", bus.iss_rdy); end
        checks++; if (bus.iss_tag !== 2'd0) begin failures++; $display("FAIL reset_iss_tag got=%0d exp=0", bus.iss_tag); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0d exp=0", bus.busy); end
        checks++; if ({bus.wb_val, bus.rsp_err, bus.set_op_ready_val, bus.clr_op_ready_val} !== 4'b0)
            begin failures++; $display("FAIL reset_pulses got=%b exp=0000",
                {bus.wb_val, bus.rsp_err, bus.set_op_ready_val, bus.clr_op_ready_val}); end
        checks++; if ({bus.wb_rd, bus.wb_data, bus.set_op_ready_idx, bus.clr_op_ready_idx} !== 47'd0)
            begin failures++; $display("FAIL reset_data got=%0h exp=0",
                {bus.wb_rd, bus.wb_data, bus.set_op_ready_idx, bus.clr_op_ready_idx}); end
        release_reset();
    endtask

    task automatic test_basic();
        drive_cycle(1'b1, 5'd5, 1'b0, 2'd0, 32'd0);
        checks++; if (obs_tag !== 2'd0) begin failures++; $display("FAIL basic_tag got=%0d exp=0", obs_tag); end
        checks++; if ({obs_clr_val, obs_clr_idx} !== {1'b1, 5'd5})
            begin failures++; $display("FAIL basic_clr got=%0d/%0d exp=1/5", obs_clr_val, obs_clr_idx); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL basic_busy_set got=%0d exp=1", bus.busy); end
        drive_cycle(1'b0, 5'd0, 1'b1, 2'd0, 32'hDEADBEEF);
        checks++; if ({bus.wb_val, bus.wb_rd, bus.wb_data} !== {1'b1, 5'd5, 32'hDEADBEEF})
            begin failures++; $display("FAIL basic_wb got=%0d/%0d/%h exp=1/5/deadbeef", bus.wb_val, bus.wb_rd, bus.wb_data); end
        checks++; if ({bus.set_op_ready_val, bus.set_op_ready_idx} !== {1'b1, 5'd5})
            begin failures++; $display("FAIL basic_set got=%0d/%0d exp=1/5", bus.set_op_ready_val, bus.set_op_ready_idx); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL basic_busy_clr got=%0d exp=0", bus.busy); end
    endtask

    task automatic test_full();
        for (int k = 1; k <= 4; k++) begin
            drive_cycle(1'b1, 5'(k), 1'b0, 2'd0, 32'd0);
            checks++; if (obs_tag !== 2'(k - 1)) begin failures++; $display("FAIL full_tag got=%0d exp=%0d", obs_tag, k - 1); end
        end
        drive_cycle(1'b1, 5'd20, 1'b0, 2'd0, 32'd0);
        checks++; if ({obs_rdy, obs_clr_val} !== 2'b00) begin failures++; $display("FAIL full_stall got=%b exp=00", {obs_rdy, obs_clr_val}); end
        drive_cycle(1'b0, 5'd0, 1'b1, 2'd2, 32'h1234);
        checks++; if ({bus.wb_val, bus.wb_rd} !== {1'b1, 5'd3}) begin failures++; $display("FAIL full_wb got=%0d/%0d exp=1/3", bus.wb_val, bus.wb_rd); end
        drive_cycle(1'b1, 5'd20, 1'b0, 2'd0, 32'd0);
        checks++; if ({obs_rdy, obs_tag} !== {1'b1, 2'd2}) begin failures++; $display("FAIL full_realloc got=%0d/%0d exp=1/2", obs_rdy, obs_tag); end
        for (int k = 0; k < 4; k++) drive_cycle(1'b0, 5'd0, 1'b1, 2'(k), 32'(k));
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL full_drain_busy got=%0d exp=0", bus.busy); end
    endtask

    task automatic test_same_rd();
        drive_cycle(1'b1, 5'd7, 1'b0, 2'd0, 32'd0);
        drive_cycle(1'b1, 5'd7, 1'b0, 2'd0, 32'd0);
`ifdef ELD_TRK_MULTI_RD_EN
        checks++; if ({obs_rdy, obs_tag} !== {1'b1, 2'd1}) begin failures++; $display("FAIL samerd_issue got=%0d/%0d exp=1/1", obs_rdy, obs_tag); end
        drive_cycle(1'b0, 5'd0, 1'b1, 2'd0, 32'hAAAA0000);
        checks++; if ({bus.wb_val, bus.wb_rd, bus.set_op_ready_val} !== {1'b1, 5'd7, 1'b0})
            begin failures++; $display("FAIL samerd_old got=%0d/%0d/%0d exp=1/7/0", bus.wb_val, bus.wb_rd, bus.set_op_ready_val); end
        drive_cycle(1'b0, 5'd0, 1'b1, 2'd1, 32'hBBBB1111);
`else
        checks++; if (obs_rdy !== 1'b0) begin failures++; $display("FAIL samerd_stall got=%0d exp=0", obs_rdy); end
        drive_cycle(1'b1, 5'd7, 1'b1, 2'd0, 32'hAAAA0000);
        checks++; if (obs_rdy !== 1'b0) begin failures++; $display("FAIL samerd_stall_rsp got=%0d exp=0", obs_rdy); end
        drive_cycle(1'b1, 5'd7, 1'b0, 2'd0, 32'd0);
        checks++; if ({obs_rdy, obs_tag} !== {1'b1, 2'd0}) begin failures++; $display("FAIL samerd_issue got=%0d/%0d exp=1/0", obs_rdy, obs_tag); end
        drive_cycle(1'b0, 5'd0, 1'b1, 2'd0, 32'hBBBB1111);
`endif
        checks++; if ({bus.wb_val, bus.wb_data, bus.set_op_ready_val, bus.set_op_ready_idx} !== {1'b1, 32'hBBBB1111, 1'b1, 5'd7})
            begin failures++; $display("FAIL samerd_young got=%0d/%h/%0d/%0d exp=1/bbbb1111/1/7",
                bus.wb_val, bus.wb_data, bus.set_op_ready_val, bus.set_op_ready_idx); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL samerd_busy got=%0d exp=0", bus.busy); end
    endtask

    task automatic test_same_cycle();
        drive_cycle(1'b1, 5'd9, 1'b0, 2'd0, 32'd0);
        drive_cycle(1'b1, 5'd9, 1'b1, 2'd0, 32'hC0FFEE00);
`ifdef ELD_TRK_MULTI_RD_EN
        checks++; if ({obs_clr_val, obs_clr_idx, obs_tag} !== {1'b1, 5'd9, 2'd1})
            begin failures++; $display("FAIL samecyc_clr got=%0d/%0d/%0d exp=1/9/1", obs_clr_val, obs_clr_idx, obs_tag); end
        checks++; if ({bus.wb_val, bus.wb_rd, bus.set_op_ready_val} !== {1'b1, 5'd9, 1'b0})
            begin failures++; $display("FAIL samecyc_wb got=%0d/%0d/%0d exp=1/9/0", bus.wb_val, bus.wb_rd, bus.set_op_ready_val); end
        drive_cycle(1'b0, 5'd0, 1'b1, 2'd1, 32'h0);
        checks++; if ({bus.set_op_ready_val, bus.set_op_ready_idx} !== {1'b1, 5'd9})
            begin failures++; $display("FAIL samecyc_set got=%0d/%0d exp=1/9", bus.set_op_ready_val, bus.set_op_ready_idx); end
`else
        checks++; if (obs_clr_val !== 1'b0) begin failures++; $display("FAIL samecyc_clr got=%0d exp=0", obs_clr_val); end
        checks++; if ({bus.wb_val, bus.wb_rd, bus.set_op_ready_val} !== {1'b1, 5'd9, 1'b1})
            begin failures++; $display("FAIL samecyc_wb got=%0d/%0d/%0d exp=1/9/1", bus.wb_val, bus.wb_rd, bus.set_op_ready_val); end
`endif
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL samecyc_busy got=%0d exp=0", bus.busy); end
    endtask

    task automatic test_err_x0();
        drive_cycle(1'b0, 5'd0, 1'b1, 2'd3, 32'h55);
        checks++; if ({bus.rsp_err, bus.wb_val, bus.set_op_ready_val, bus.busy} !== 4'b1000)
            begin failures++; $display("FAIL err_pulse got=%b exp=1000", {bus.rsp_err, bus.wb_val, bus.set_op_ready_val, bus.busy}); end
        drive_cycle(1'b1, 5'd0, 1'b0, 2'd0, 32'd0);
        checks++; if ({bus.rsp_err, obs_rdy, obs_clr_val, bus.busy} !== 4'b0101)
            begin failures++; $display("FAIL err_x0_issue got=%b exp=0101", {bus.rsp_err, obs_rdy, obs_clr_val, bus.busy}); end
        drive_cycle(1'b0, 5'd0, 1'b1, 2'd0, 32'h66);
        checks++; if ({bus.rsp_err, bus.wb_val, bus.set_op_ready_val, bus.busy} !== 4'b0000)
            begin failures++; $display("FAIL err_x0_rsp got=%b exp=0000", {bus.rsp_err, bus.wb_val, bus.set_op_ready_val, bus.busy}); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) drive_cycle(1'b1, 5'(10 + k), 1'b0, 2'd0, 32'd0);
        for (int k = 0; k < 4; k++) begin
            drive_cycle(1'b0, 5'd0, 1'b1, 2'(k), 32'(100 + k));
            checks++; if ({bus.wb_val, bus.wb_rd, bus.wb_data} !== {1'b1, 5'(10 + k), 32'(100 + k)})
                begin failures++; $display("FAIL b2b_wb got=%0d/%0d/%0d exp=1/%0d/%0d", bus.wb_val, bus.wb_rd, bus.wb_data, 10 + k, 100 + k); end
        end
        drive_cycle(1'b0, 5'd0, 1'b0, 2'd0, 32'd0);
        checks++; if ({bus.wb_val, bus.busy} !== 2'b00) begin failures++; $display("FAIL b2b_idle got=%b exp=00", {bus.wb_val, bus.busy}); end
    endtask

    task automatic test_random();
        logic iv, rv;
        logic [4:0] ird;
        logic [1:0] rtag;
        for (int n = 0; n < 400; n++) begin
            iv   = 1'($urandom_range(0, 1));
            ird  = 5'($urandom_range(0, 3));
            rv   = ($urandom_range(0, 3) != 0);
            rtag = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) != 0)
                for (int k = 0; k < 4; k++) if (!m_valid[rtag]) rtag = 2'($urandom_range(0, 3));
            drive_cycle(iv, ird, rv, rtag, $urandom);
            checks++; if (obs_rdy !== exp_rdy) begin failures++; $display("FAIL rnd_rdy cyc=%0d got=%0d exp=%0d", n, obs_rdy, exp_rdy); end
            if (exp_rdy) begin
                checks++; if (obs_tag !== exp_tag) begin failures++; $display("FAIL rnd_tag cyc=%0d got=%0d exp=%0d", n, obs_tag, exp_tag); end
            end
            checks++; if ({obs_clr_val, obs_clr_idx} !== {exp_clr_val, exp_clr_idx})
                begin failures++; $display("FAIL rnd_clr cyc=%0d got=%0d/%0d exp=%0d/%0d", n, obs_clr_val, obs_clr_idx, exp_clr_val, exp_clr_idx); end
            checks++; if (bus.wb_val !== exp_wb_val) begin failures++; $display("FAIL rnd_wb_val cyc=%0d got=%0d exp=%0d", n, bus.wb_val, exp_wb_val); end
            if (exp_wb_val) begin
                checks++; if ({bus.wb_rd, bus.wb_data} !== {exp_wb_rd, exp_wb_data})
                    begin failures++; $display("FAIL rnd_wb_data cyc=%0d got=%0d/%h exp=%0d/%h", n, bus.wb_rd, bus.wb_data, exp_wb_rd, exp_wb_data); end
            end
            checks++; if (bus.set_op_ready_val !== exp_set_val) begin failures++; $display("FAIL rnd_set cyc=%0d got=%0d exp=%0d", n, bus.set_op_ready_val, exp_set_val); end
            if (exp_set_val) begin
                checks++; if (bus.set_op_ready_idx !== exp_set_idx) begin failures++; $display("FAIL rnd_set_idx cyc=%0d got=%0d exp=%0d", n, bus.set_op_ready_idx, exp_set_idx); end
            end
            checks++; if (bus.rsp_err !== exp_err) begin failures++; $display("FAIL rnd_err cyc=%0d got=%0d exp=%0d", n, bus.rsp_err, exp_err); end
            checks++; if (bus.busy !== exp_busy) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%0d exp=%0d", n, bus.busy, exp_busy); end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        release_reset();
        for (int k = 1; k <= 3; k++) drive_cycle(1'b1, 5'(k), 1'b0, 2'd0, 32'd0);
        apply_reset();
        checks++; if ({bus.iss_rdy, bus.iss_tag, bus.busy} !== {1'b1, 2'd0, 1'b0})
            begin failures++; $display("FAIL rstmid_state got=%0d/%0d/%0d exp=1/0/0", bus.iss_rdy, bus.iss_tag, bus.busy); end
        checks++; if ({bus.wb_val, bus.set_op_ready_val, bus.clr_op_ready_val, bus.rsp_err} !== 4'b0000)
            begin failures++; $display("FAIL rstmid_pulses got=%b exp=0000", {bus.wb_val, bus.set_op_ready_val, bus.clr_op_ready_val, bus.rsp_err}); end
        release_reset();
        drive_cycle(1'b0, 5'd0, 1'b1, 2'd1, 32'h77);
        checks++; if ({bus.rsp_err, bus.wb_val, bus.set_op_ready_val} !== 3'b100)
            begin failures++; $display("FAIL rstmid_stale got=%b exp=100", {bus.rsp_err, bus.wb_val, bus.set_op_ready_val}); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_same_rd();
        test_same_cycle();
        test_err_x0();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
